// File: rtl/neuron_feeder_if.sv
// Handshake and data bundle between the feeder, its sample source, the neuron and the result sink.
// The master view is the feeder itself; the slave view is everything around it.
interface neuron_feeder_if #(
  parameter int N_INPUTS = 9,
  parameter int DATA_W   = 9
);
  logic [DATA_W-1:0]          in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [N_INPUTS*DATA_W-1:0] neu_inputs;
  logic                       neu_start;
  logic [DATA_W-1:0]          neu_out;
  logic                       neu_end;
  logic [DATA_W-1:0]          res_data;
  logic                       res_valid;
  logic                       res_ready;
  logic                       timeout_err;

  modport master (
    input  in_data, in_valid, neu_out, neu_end, res_ready,
    output in_ready, neu_inputs, neu_start, res_data, res_valid, timeout_err
  );

  modport slave (
    output in_data, in_valid, neu_out, neu_end, res_ready,
    input  in_ready, neu_inputs, neu_start, res_data, res_valid, timeout_err
  );
endinterface

// File: rtl/neuron_feeder.sv
// Sequencing front-end for one neuron: gathers N_INPUTS samples, pulses start,
// waits for a fresh end_ rising edge (or a timeout) and offers the result downstream.
module neuron_feeder #(
  parameter int N_INPUTS = 9,
  parameter int DATA_W   = 9,
  parameter int TIMEOUT  = 31
) (
  input logic            clk,
  input logic            rst_n,
  neuron_feeder_if.master bus
);
  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  typedef enum logic [1:0] {FILL, START, WAIT, HOLD} state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [7:0]                 wcnt_q, wcnt_d;
  logic                       end_prev_q, end_prev_d;
  logic [N_INPUTS*DATA_W-1:0] vec_q, vec_d;
  logic [DATA_W-1:0]          res_data_q, res_data_d;
  logic                       timeout_err_q, timeout_err_d;

  logic accept;
  logic last;
  logic end_rise;
  logic wait_expired;

  assign accept       = bus.in_valid && (state_q == FILL);
  assign last         = (cnt_q == CNT_W'(N_INPUTS - 1));
  assign end_rise     = bus.neu_end && !end_prev_q;
  assign wait_expired = (wcnt_q == 8'(TIMEOUT)) && !end_rise;

  assign bus.neu_inputs  = vec_q;
  assign bus.res_data    = res_data_q;
  assign bus.timeout_err = timeout_err_q;

  // State and datapath registers; everything returns to idle FILL on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      cnt_q         <= '0;
      wcnt_q        <= '0;
      end_prev_q    <= 1'b1;
      vec_q         <= '0;
      res_data_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wcnt_q        <= wcnt_d;
      end_prev_q    <= end_prev_d;
      vec_q         <= vec_d;
      res_data_q    <= res_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state sequencing through fill, start pulse, wait for result and downstream hold.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && last) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (end_rise || wait_expired) state_d = HOLD;
      HOLD:    if (bus.res_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Handshake outputs decoded purely from state.
  always_comb begin
    bus.in_ready  = (state_q == FILL);
    bus.neu_start = (state_q == START);
    bus.res_valid = (state_q == HOLD);
  end

  // Datapath: sample capture, end_ edge tracking, wait counter and result capture.
  always_comb begin
    cnt_d         = cnt_q;
    wcnt_d        = wcnt_q;
    end_prev_d    = end_prev_q;
    vec_d         = vec_q;
    res_data_d    = res_data_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          vec_d[int'(cnt_q)*DATA_W +: DATA_W] = bus.in_data;
          cnt_d = last ? '0 : cnt_q + 1'b1;
        end
      end
      START: begin
        // Pretend end_ was already high so a level left over from the last run is not an edge.
        end_prev_d = 1'b1;
        wcnt_d     = '0;
      end
      WAIT: begin
        end_prev_d = bus.neu_end;
        if (end_rise) begin
          res_data_d = bus.neu_out;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
          if (wait_expired) begin
            res_data_d    = '0;
            timeout_err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_neuron_feeder.sv
// Directed bench for neuron_feeder: the initial block plays sample source, neuron and sink.
module tb_neuron_feeder;
  localparam int N_INPUTS = 9;
  localparam int DATA_W   = 9;
  localparam int TIMEOUT  = 31;

  logic clk;
  logic rst_n;

  neuron_feeder_if #(.N_INPUTS(N_INPUTS), .DATA_W(DATA_W)) bus ();

  neuron_feeder #(.N_INPUTS(N_INPUTS), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  logic [DATA_W-1:0] samp [N_INPUTS];
  logic [DATA_W-1:0] exp_q [$];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [N_INPUTS*DATA_W-1:0] pack_samp();
    logic [N_INPUTS*DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < N_INPUTS; i++) v[i*DATA_W +: DATA_W] = samp[i];
    return v;
  endfunction

  task automatic check_reset(input string tag);
    chk(tag, {bus.in_ready, bus.neu_start, bus.res_valid, bus.res_data, bus.timeout_err, bus.neu_inputs},
        {1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 81'd0});
  endtask

  // Offers samp[0..n-1]; with gapped set, in_valid alternates 1,0,1,0...
  task automatic feed(input int n, input bit gapped);
    int k = 0;
    int cyc = 0;
    bit ph = 1'b0;
    bit acc;
    bit start_seen = 1'b0;
    while (k < n && cyc < 200) begin
      bus.in_valid = gapped ? !ph : 1'b1;
      ph = !ph;
      bus.in_data = samp[k];
      acc = bus.in_valid && bus.in_ready;
      if (bus.neu_start) start_seen = 1'b1;
      step();
      cyc++;
      if (acc) k++;
    end
    bus.in_valid = 1'b0;
    chk("feed_count", k, n);
    chk("feed_cycles", cyc, gapped ? 2*n-1 : n);
    chk("no_start_in_fill", start_seen, 1'b0);
  endtask

  // Called on the cycle right after the last sample was taken.
  task automatic after_fill();
    chk("start_pulse", {bus.neu_start, bus.in_ready}, 2'b10);
    chk("vector", bus.neu_inputs, pack_samp());
  endtask

  task automatic wait_res(input int exp_lat, input logic exp_terr);
    int n = 0;
    logic [DATA_W-1:0] e;
    while (bus.res_valid !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("res_latency", n, exp_lat);
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("res_data", bus.res_data, e);
    chk("timeout_err", bus.timeout_err, exp_terr);
    chk("vec_held", bus.neu_inputs, pack_samp());
    if (bus.res_ready) begin
      step();
      chk("back_to_fill", {bus.in_ready, bus.res_valid}, 2'b10);
    end
  endtask

  // Neuron model: start is high now (cycle 0); end_ falls at cycle drop, rises with res at cycle rise.
  task automatic neuron_run(input int drop, input int rise, input logic [DATA_W-1:0] res, input logic exp_terr);
    for (int c = 1; c <= rise; c++) begin
      step();
      if (c == 1) chk("start_one_cycle", {bus.neu_start, bus.in_ready}, 2'b00);
      if (c == drop) bus.neu_end = 1'b0;
    end
    chk("no_early_result", bus.res_valid, 1'b0);
    bus.neu_out = res;
    bus.neu_end = 1'b1;
    exp_q.push_back(res);
    wait_res(1, exp_terr);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.neu_out   = '0;
    bus.neu_end   = 1'b0;
    bus.res_ready = 1'b1;
    #2;
    check_reset("reset_initial");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Basic run: samples 1..9, neuron answers 45.
    for (int i = 0; i < N_INPUTS; i++) samp[i] = DATA_W'(i + 1);
    feed(N_INPUTS, 1'b0);
    after_fill();
    neuron_run(0, 11, 9'd45, 1'b0);

    // Stale end_: still high from the previous run, drops, then rises with 7.
    for (int i = 0; i < N_INPUTS; i++) samp[i] = DATA_W'(9'h1FF - i*7);
    bus.neu_out = 9'h063;
    feed(N_INPUTS, 1'b0);
    after_fill();
    neuron_run(2, 11, 9'd7, 1'b0);

    // Back-pressure: sink stalls 20 cycles while the source keeps offering data.
    for (int i = 0; i < N_INPUTS; i++) samp[i] = DATA_W'(i*37 + 5);
    feed(N_INPUTS, 1'b0);
    after_fill();
    bus.res_ready = 1'b0;
    neuron_run(1, 10, 9'h1FF, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 9'h0AA;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_hold", {bus.res_valid, bus.res_data, bus.in_ready, bus.neu_inputs},
          {1'b1, 9'h1FF, 1'b0, pack_samp()});
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    step();
    chk("bp_release", {bus.in_ready, bus.res_valid}, 2'b10);

    // Timeout: end_ stuck low, result forced to zero and the error flag set.
    for (int i = 0; i < N_INPUTS; i++) samp[i] = DATA_W'(9'h0F0 + i);
    feed(N_INPUTS, 1'b0);
    after_fill();
    bus.neu_end = 1'b0;
    bus.neu_out = 9'h123;
    exp_q.push_back(9'd0);
    wait_res(TIMEOUT + 2, 1'b1);

    // Gapped input stream; timeout_err must survive a good run.
    for (int i = 0; i < N_INPUTS; i++) samp[i] = DATA_W'(9'h1F0 - i*3);
    feed(N_INPUTS, 1'b1);
    after_fill();
    neuron_run(0, 12, 9'h055, 1'b1);

    // Reset in the middle of filling, then a fresh full vector.
    for (int i = 0; i < N_INPUTS; i++) samp[i] = DATA_W'(9'h100 + i);
    feed(5, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset("reset_async");
    step();
    check_reset("reset_held");
    rst_n = 1'b1;
    step();
    for (int i = 0; i < N_INPUTS; i++) samp[i] = DATA_W'(9'h080 + 5*i);
    feed(N_INPUTS, 1'b0);
    after_fill();
    bus.neu_end = 1'b0;
    neuron_run(0, 11, 9'h0AB, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
